// File: rtl/matriz_pkg.sv
// Shared types and helpers for the matrix scan controller.
// Holds the controller state enum, the scan-order enum, the index-width helper
// and a generic {row, col} index pair type.
package matriz_pkg;

  // Widest index the pair type can carry; real counters use idx_w().
  localparam int IDX_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
  } state_t;

  typedef enum logic {
    ROW_MAJOR = 1'b0,
    COL_MAJOR = 1'b1
  } scan_order_t;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] row;
    logic [IDX_MAX_W-1:0] col;
  } idx_pair_t;

  // Index width for a dimension of n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matriz_scan_ctrl_if.sv
// Handshake bundle between a matrix producer/consumer and matriz_scan_ctrl.
// Carries control (start, cfg_col_major, busy, done), the input element stream
// and the indexed output stream. slave = controller side, master = environment side.
interface matriz_scan_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 1,
  parameter int COL_W  = 2
);
  logic              start;
  logic              cfg_col_major;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;
  logic              out_last;
  logic              busy;
  logic              done;

  modport slave (
    input  start, cfg_col_major, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last, busy, done
  );

  modport master (
    output start, cfg_col_major, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last, busy, done
  );
endinterface

// File: rtl/matriz_idx_counter.sv
// 2-D (row, col) index counter with clear, advance and row/column-major order.
// Latency: index updates on the edge after clr/adv; at_last is combinational from the index.
// Backpressure: holds its index whenever adv is low.
// Ports: clk, rst_n (sync, active-low), clr, adv, order, row, col, at_last.
module matriz_idx_counter
  import matriz_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     adv,
  input  scan_order_t              order,
  output logic [idx_w(ROWS)-1:0]   row,
  output logic [idx_w(COLS)-1:0]   col,
  output logic                     at_last
);
  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic row_end;
  logic col_end;

  // Wraps are explicit compares so non-power-of-two dimensions stay in range.
  assign row_end = (row == ROW_LAST);
  assign col_end = (col == COL_LAST);
  assign at_last = row_end && col_end;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (order == ROW_MAJOR) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        if (row_end) begin
          row <= '0;
          col <= col_end ? '0 : col + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matriz_scan_ctrl.sv
// Loads one ROWS x COLS matrix row-major, then replays it with (row, col) indices.
// Latency: first output valid one cycle after the last input handshake; 1 element/cycle.
// Backpressure: out_* held stable while out_ready is low; in_ready only in LOAD.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of matriz_scan_ctrl_if).
module matriz_scan_ctrl
  import matriz_pkg::*;
#(
  parameter int ROWS   = 2,
  parameter int COLS   = 3,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  matriz_scan_ctrl_if.slave  bus
);
  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);

  state_t      state_q, state_d;
  scan_order_t order_q;
  logic        done_q, done_d;

  logic             wr_clr, wr_adv, wr_last;
  logic             rd_clr, rd_adv, rd_last;
  logic [ROW_W-1:0] wr_r, rd_r;
  logic [COL_W-1:0] wr_c, rd_c;

  logic [DATA_W-1:0] mem [ROWS][COLS];

  matriz_idx_counter #(.ROWS(ROWS), .COLS(COLS)) u_wr_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wr_clr),
    .adv     (wr_adv),
    .order   (ROW_MAJOR),
    .row     (wr_r),
    .col     (wr_c),
    .at_last (wr_last)
  );

  matriz_idx_counter #(.ROWS(ROWS), .COLS(COLS)) u_rd_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (rd_clr),
    .adv     (rd_adv),
    .order   (order_q),
    .row     (rd_r),
    .col     (rd_c),
    .at_last (rd_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      order_q <= ROW_MAJOR;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      // Replay order is only captured alongside an accepted start.
      if (state_q == IDLE && bus.start)
        order_q <= scan_order_t'(bus.cfg_col_major);
    end
  end

  // Storage is deliberately not reset; a fresh load overwrites every entry.
  always_ff @(posedge clk) begin
    if (wr_adv)
      mem[wr_r][wr_c] <= bus.in_data;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    wr_clr  = 1'b0;
    wr_adv  = 1'b0;
    rd_clr  = 1'b0;
    rd_adv  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          wr_clr  = 1'b1;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          wr_adv = 1'b1;
          if (wr_last) begin
            state_d = SCAN;
            rd_clr  = 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.out_ready) begin
          rd_adv = 1'b1;
          if (rd_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode registered state only.
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == SCAN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.out_row   = rd_r;
  assign bus.out_col   = rd_c;
  assign bus.out_last  = (state_q == SCAN) && rd_last;
  assign bus.out_data  = (state_q == SCAN) ? mem[rd_r][rd_c] : '0;

endmodule
